// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: PC step, buffer depth,
// FSM encoding and the buffered {instruction, pc} entry.
package fetch_pkg;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam int          FETCH_FIFO_DEPTH = 2;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small output buffer of fetched {instruction, pc} pairs with flush.
// Push and pop may coincide; a push into a full buffer is accepted only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     entry_vec [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != CNT_W'(DEPTH)) || pop_ok);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = entry_vec[rd_ptr_reg];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Sequential instruction fetcher: issues one word address per cycle to a
// registered memory, buffers responses and hands them out with valid/ready.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_e     state_reg;
    logic [31:0]      pc_reg;
    logic             inflight_reg;
    logic [31:0]      inflight_pc_reg;
    logic             misalign_err_reg;

    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_data;
    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;

    // Slots already claimed once this cycle's pop retires: buffered plus the
    // response still on its way back. A new request needs one free slot.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_reg) - OCC_W'(pop);
    assign issue     = (state_reg == ST_RUN) && !redirect_valid
                       && (occupancy <= OCC_W'(FIFO_DEPTH - 1));

    // A redirect kills the response that is returning this cycle.
    assign push      = inflight_reg && !redirect_valid;
    assign push_data = '{instr: imem_instr, pc: inflight_pc_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_HALT;
            pc_reg           <= RESET_PC;
            inflight_reg     <= 1'b0;
            inflight_pc_reg  <= '0;
            misalign_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_HALT: if (fetch_enable)  state_reg <= ST_RUN;
                ST_RUN:  if (!fetch_enable) state_reg <= ST_HALT;
                default: state_reg <= ST_HALT;
            endcase

            misalign_err_reg <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid) begin
                pc_reg <= align_pc(redirect_pc);
            end else if (issue) begin
                pc_reg <= pc_reg + PC_INCR;
            end

            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign imem_addr    = pc_reg;
    assign out_instr    = fifo_head.instr;
    assign out_pc       = fifo_head.pc;
    assign misalign_err = misalign_err_reg;

endmodule
